move_player: RTL and testbench

- Sits directly downstream of the solver. Consumes its move stream (start block, end block, enable pulse) and buffers moves in a small FIFO.
- Paces the solver through the continue handshake, then replays moves one at a time onto its own copy of the board for the display path.
- Stepping is by user button or by an internal timer. Counts applied moves and flags illegal moves.

---
 rtl/move_player_if.sv | 18 +
 rtl/move_player.sv | 142 ++++++++++++++
 tb/tb_move_player.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_player_if.sv
// Move stream from the solver into the move player, plus the continue pacing pulse back.
interface move_player_if;
  logic [3:0] i_start_block;
  logic [3:0] i_end_block;
  logic       i_en;
  logic       i_solver_finished;
  logic       o_continue;

  modport master (
    output i_start_block, i_end_block, i_en, i_solver_finished,
    input  o_continue
  );

  modport slave (
    input  i_start_block, i_end_block, i_en, i_solver_finished,
    output o_continue
  );
endinterface

// File: rtl/move_player.sv
// Buffers solver moves in a small FIFO, paces the solver with continue pulses and
// replays moves onto a private board copy on a manual or timed step.
module move_player #(
  parameter int DEPTH       = 8,
  parameter int STEP_CYCLES = 12_000_000
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [63:0]  i_klotski,
  input  logic         i_step,
  input  logic         i_auto,
  move_player_if.slave mv,
  output logic [63:0]  o_klotski,
  output logic [9:0]   o_move_count,
  output logic         o_done,
  output logic         o_error
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int TW = $clog2(STEP_CYCLES);
  localparam logic [OW-1:0] FULL_OCC   = OW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  state_t        state_q;
  logic [7:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [OW-1:0] occ_q;
  logic [TW-1:0] timer_q;
  logic          finished_q;
  logic          pending_q;
  logic          cont_q;

  logic          running;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          overflow;
  logic          trigger;
  logic          legal;
  logic [3:0]    head_start;
  logic [3:0]    head_end;
  logic [5:0]    start_lsb;
  logic [5:0]    end_lsb;
  logic [OW-1:0] occ_next;

  assign mv.o_continue = cont_q;

  // NOTE: every variable below is assigned on every pass, so no latch can be inferred.
  always_comb begin
    running    = (state_q == S_RUN) && !i_load;
    fifo_empty = (occ_q == '0);
    fifo_full  = (occ_q == FULL_OCC);
    push       = running && mv.i_en && !fifo_full;
    overflow   = running && mv.i_en && fifo_full;
    trigger    = running && !fifo_empty && (i_auto ? (timer_q == TIMER_LAST) : i_step);
    {head_start, head_end} = fifo_mem[rd_ptr_q];
    // Cell b sits at bits [63-4b -: 4], whose LSB is 4*(15-b).
    start_lsb  = {~head_start, 2'b00};
    end_lsb    = {~head_end, 2'b00};
    legal      = (o_klotski[end_lsb +: 4] == 4'd0) && (o_klotski[start_lsb +: 4] != 4'd0);
    occ_next   = occ_q + OW'(push) - OW'(trigger);
  end

  // NOTE: FIFO storage is not reset; pointers and occupancy alone say which entries are valid.
  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {mv.i_start_block, mv.i_end_block};
  end

  // NOTE: state is updated with non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      timer_q      <= '0;
      finished_q   <= 1'b0;
      pending_q    <= 1'b0;
      cont_q       <= 1'b0;
      o_klotski    <= '0;
      o_move_count <= '0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
    end else if (i_load) begin
      state_q      <= S_RUN;
      o_klotski    <= i_klotski;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      timer_q      <= '0;
      finished_q   <= 1'b0;
      pending_q    <= 1'b0;
      cont_q       <= 1'b0;
      o_move_count <= '0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      cont_q <= 1'b0;
      if (state_q == S_RUN) begin
        if (mv.i_solver_finished) finished_q <= 1'b1;
        if (push)    wr_ptr_q <= wr_ptr_q + 1'b1;
        if (trigger) rd_ptr_q <= rd_ptr_q + 1'b1;
        occ_q <= occ_next;

        if (!i_auto || trigger) timer_q <= '0;
        else if (!fifo_empty)   timer_q <= timer_q + 1'b1;

        // A push that fills the FIFO defers its continue until space frees up.
        if (push) begin
          if (occ_next != FULL_OCC) cont_q    <= 1'b1;
          else                      pending_q <= 1'b1;
        end else if (trigger && pending_q) begin
          cont_q    <= 1'b1;
          pending_q <= 1'b0;
        end

        if (trigger) begin
          if (legal) begin
            o_klotski[end_lsb +: 4]   <= o_klotski[start_lsb +: 4];
            o_klotski[start_lsb +: 4] <= 4'd0;
            if (o_move_count != 10'h3FF) o_move_count <= o_move_count + 10'd1;
          end else begin
            o_error <= 1'b1;
            state_q <= S_ERR;
          end
        end

        if (overflow) begin
          o_error <= 1'b1;
          state_q <= S_ERR;
        end else if (finished_q && fifo_empty && !push) begin
          o_done  <= 1'b1;
          state_q <= S_DONE;
        end
      end
    end
  end
endmodule

// File: tb/tb_move_player.sv
// Directed bench for move_player: vector table of single moves plus hand-written
// sequences for backpressure, overflow, auto stepping, saturation and reset.
module tb_move_player;
  localparam int DEPTH = 4;
  localparam int STEP  = 4;

  localparam logic [63:0] B0 = 64'h123456789ABCDEF0;
  localparam logic [63:0] B1 = 64'h123456789ABCDE0F;  // after 14->15
  localparam logic [63:0] B2 = 64'h123456789ABCD0EF;  // after 13->14
  localparam logic [63:0] B3 = 64'h123456789ABC0DEF;  // after 12->13
  localparam logic [63:0] B4 = 64'h123456780ABC9DEF;  // after 8->12

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_load = 1'b0;
  logic [63:0] i_klotski = '0;
  logic        i_step = 1'b0;
  logic        i_auto = 1'b0;
  logic [63:0] o_klotski;
  logic [9:0]  o_move_count;
  logic        o_done;
  logic        o_error;

  move_player_if mv();

  move_player #(.DEPTH(DEPTH), .STEP_CYCLES(STEP)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (i_load),
    .i_klotski   (i_klotski),
    .i_step      (i_step),
    .i_auto      (i_auto),
    .mv          (mv),
    .o_klotski   (o_klotski),
    .o_move_count(o_move_count),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load(input logic [63:0] b);
    i_load = 1'b1;
    i_klotski = b;
    tick();
    i_load = 1'b0;
  endtask

  task automatic push(input logic [3:0] s, input logic [3:0] e);
    mv.i_en = 1'b1;
    mv.i_start_block = s;
    mv.i_end_block = e;
    tick();
    mv.i_en = 1'b0;
  endtask

  task automatic step();
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [63:0] board;
    logic [3:0]  s;
    logic [3:0]  e;
    logic [63:0] exp_board;
    logic [9:0]  exp_count;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] ms[4];
    logic [3:0] me[4];
    logic [63:0] exp_b;

    vecs[0] = '{"tail",      B0,                    4'd14, 4'd15, B1,                    10'd1, 1'b0};
    vecs[1] = '{"far",       B0,                    4'd11, 4'd15, 64'h123456789AB0DEFC, 10'd1, 1'b0};
    vecs[2] = '{"occupied",  64'h3500000000000000, 4'd0,  4'd1,  64'h3500000000000000, 10'd0, 1'b1};
    vecs[3] = '{"same_cell", B0,                    4'd3,  4'd3,  B0,                    10'd0, 1'b1};
    vecs[4] = '{"blank_src", 64'h0012000000000000, 4'd0,  4'd1,  64'h0012000000000000, 10'd0, 1'b1};
    vecs[5] = '{"corner",    64'h7000000000000000, 4'd0,  4'd15, 64'h0000000000000007, 10'd1, 1'b0};
    vecs[6] = '{"up",        64'h0000000000004000, 4'd12, 4'd8,  64'h0000000040000000, 10'd1, 1'b0};

    ms[0] = 4'd14; me[0] = 4'd15;
    ms[1] = 4'd13; me[1] = 4'd14;
    ms[2] = 4'd12; me[2] = 4'd13;
    ms[3] = 4'd8;  me[3] = 4'd12;

    mv.i_en = 1'b0;
    mv.i_start_block = '0;
    mv.i_end_block = '0;
    mv.i_solver_finished = 1'b0;

    // Reset state
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    check("rst_board", o_klotski, 64'd0);
    check("rst_count", 64'(o_move_count), 64'd0);
    check("rst_cont", 64'(mv.o_continue), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_err", 64'(o_error), 64'd0);

    // Moves in S_IDLE are ignored
    push(4'd14, 4'd15);
    check("idle_cont", 64'(mv.o_continue), 64'd0);
    check("idle_err", 64'(o_error), 64'd0);

    // Single-move vector table
    foreach (vecs[i]) begin
      load(vecs[i].board);
      check({vecs[i].name, "_load"}, o_klotski, vecs[i].board);
      push(vecs[i].s, vecs[i].e);
      check({vecs[i].name, "_cont"}, 64'(mv.o_continue), 64'd1);
      step();
      check({vecs[i].name, "_cont_drop"}, 64'(mv.o_continue), 64'd0);
      check({vecs[i].name, "_board"}, o_klotski, vecs[i].exp_board);
      check({vecs[i].name, "_count"}, 64'(o_move_count), 64'(vecs[i].exp_count));
      check({vecs[i].name, "_err"}, 64'(o_error), 64'(vecs[i].exp_err));
    end

    // Backpressure: continue after pushes 1-3, deferred continue after the pop
    load(B0);
    for (int i = 0; i < 4; i++) begin
      push(ms[i], me[i]);
      check($sformatf("bp_cont_push%0d", i), 64'(mv.o_continue), (i < 3) ? 64'd1 : 64'd0);
      tick();
    end
    check("bp_board_held", o_klotski, B0);
    step();
    check("bp_cont_after_pop", 64'(mv.o_continue), 64'd1);
    check("bp_board", o_klotski, B1);
    tick();
    check("bp_cont_single", 64'(mv.o_continue), 64'd0);

    // Refill to full, then overflow
    push(4'd1, 4'd0);
    check("full_cont", 64'(mv.o_continue), 64'd0);
    check("full_err", 64'(o_error), 64'd0);
    push(4'd2, 4'd0);
    check("ovf_err", 64'(o_error), 64'd1);
    check("ovf_count", 64'(o_move_count), 64'd1);
    step();
    check("ovf_board_held", o_klotski, B1);
    check("ovf_done", 64'(o_done), 64'd0);
    load(64'h3500000000000000);
    check("reload_err", 64'(o_error), 64'd0);
    check("reload_board", o_klotski, 64'h3500000000000000);
    check("reload_count", 64'(o_move_count), 64'd0);

    // Auto stepping: pushes at k=0..2, finished at k=3, applies at k=4,8,12
    load(B0);
    i_auto = 1'b1;
    for (int k = 0; k < 14; k++) begin
      mv.i_en = (k < 3);
      if (k < 3) begin
        mv.i_start_block = ms[k];
        mv.i_end_block = me[k];
      end
      mv.i_solver_finished = (k == 3);
      tick();
      mv.i_en = 1'b0;
      mv.i_solver_finished = 1'b0;
      exp_b = (k < 4) ? B0 : (k < 8) ? B1 : (k < 12) ? B2 : B3;
      check($sformatf("auto_board_k%0d", k), o_klotski, exp_b);
      if (k >= 11) check($sformatf("auto_done_k%0d", k), 64'(o_done), (k >= 13) ? 64'd1 : 64'd0);
    end
    check("auto_count", 64'(o_move_count), 64'd3);
    push(4'd11, 4'd12);
    check("done_ignore_cont", 64'(mv.o_continue), 64'd0);
    check("done_hold", 64'(o_done), 64'd1);
    i_auto = 1'b0;

    // Simultaneous push and pop with the FIFO half full
    load(B0);
    push(ms[0], me[0]);
    push(ms[1], me[1]);
    mv.i_en = 1'b1;
    mv.i_start_block = ms[2];
    mv.i_end_block = me[2];
    i_step = 1'b1;
    tick();
    mv.i_en = 1'b0;
    i_step = 1'b0;
    check("sim_board", o_klotski, B1);
    check("sim_cont", 64'(mv.o_continue), 64'd1);
    step();
    check("sim_order2", o_klotski, B2);
    step();
    check("sim_order3", o_klotski, B3);
    step();
    check("sim_empty_board", o_klotski, B3);
    check("sim_empty_count", 64'(o_move_count), 64'd3);
    check("sim_empty_err", 64'(o_error), 64'd0);
    for (int i = 0; i < 4; i++) begin
      push(ms[3], me[3]);
      check($sformatf("sim_refill_cont%0d", i), 64'(mv.o_continue), (i < 3) ? 64'd1 : 64'd0);
    end
    step();
    check("sim_refill_board", o_klotski, B4);

    // Move counter saturation: 1025 legal ping-pong moves
    load(B0);
    push(4'd14, 4'd15);
    for (int j = 1; j <= 1024; j++) begin
      mv.i_en = 1'b1;
      mv.i_start_block = j[0] ? 4'd15 : 4'd14;
      mv.i_end_block   = j[0] ? 4'd14 : 4'd15;
      i_step = 1'b1;
      tick();
    end
    mv.i_en = 1'b0;
    step();
    check("sat_count", 64'(o_move_count), 64'd1023);
    check("sat_board", o_klotski, B1);
    check("sat_err", 64'(o_error), 64'd0);

    // Reset coinciding with an apply
    load(B0);
    push(4'd14, 4'd15);
    i_step = 1'b1;
    i_rst = 1'b1;
    tick();
    i_step = 1'b0;
    i_rst = 1'b0;
    check("rst_mid_board", o_klotski, 64'd0);
    check("rst_mid_count", 64'(o_move_count), 64'd0);
    step();
    check("rst_mid_idle", o_klotski, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
